fp_align_seq: RTL and testbench
===============================

Name: fp_align_seq

Overview:
Multicycle alignment sequencer for the floating-point add/sub path.
- Accepts two single-precision operands on a valid/ready handshake.
- Computes the exponent difference on one shared Sub8bits instance and swaps operands so the larger exponent is "L".
- Right-shifts the smaller significand one bit per clock, with guard/round/sticky.
- Presents aligned significands and the common exponent to the downstream mantissa adder/subtractor.

Parameters:
- EXP_W, 8: exponent field width. Must stay 8, because Sub8bits is fixed width.
- MAN_W, 23: stored fraction width.
- SAT, 27: shift count at or above which MantS collapses into sticky (MAN_W+4).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- A  in  32  operand A (sign, exp, frac)
- B  in  32  operand B
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- Exp  out  8  effective exponent of the larger operand
- MantL  out  24  larger significand, hidden bit included
- MantS  out  27  smaller significand aligned, as {24 bits, G, R, S}
- SignL  out  1  sign of the larger-exponent operand
- SignS  out  1  sign of the other operand
- Swap  out  1  1 if B supplied L

Behaviour:
- One clock domain.
- rst_n is asynchronous and active-low: assertion immediately forces state IDLE and clears out_valid, Exp, MantL, MantS, SignL, SignS and Swap to 0.
- in_ready is decoded from state IDLE, so it reads 1 during and after reset.
- Effective exponent:
  - exponent field 0 → effective exponent 1 with hidden bit 0;
  - otherwise the field value with hidden bit 1.
- Inf/NaN fields are not special-cased.
- States: IDLE, DIFF, NEG, SHIFT, DONE.
- IDLE:
  - in_valid&in_ready latches A and B → DIFF.
  - Nothing else changes.
- DIFF:
  - Sub8bits computes effA-effB with Ci=0.
  - Co=1 means borrow (effA<effB); F is the difference.
  - No borrow: L=A, D=F. Equal exponents never swap, and no mantissa compare is done.
  - Borrow → NEG.
  - Otherwise → SHIFT if D>0, else → DONE.
- NEG:
  - Same Sub8bits instance computes effB-effA; D=F, Swap=1, L=B.
  - → SHIFT if D>0, else → DONE.
- SHIFT:
  - MantS is initialised to {smaller significand, 3'b000}. The counter is loaded with D.
  - If D>=SAT: in a single cycle, MantS becomes {26'b0, OR of all bits}, then → DONE.
  - Otherwise, each cycle: MantS becomes {0, MantS[26:2], MantS[1]|MantS[0]} and the counter decrements; → DONE when the counter reaches 1.
- DONE:
  - out_valid=1 and all outputs are held stable.
  - out_valid&out_ready → IDLE. No same-cycle acceptance of a new pair.
- Latency: out_valid rises 1+S+K clocks after the accepting edge, where S=Swap and K = 0 if D=0, 1 if D>=SAT, else D.
- Reset mid-operation abandons the transaction with no output. The first post-reset transaction behaves normally.
- in_valid is ignored outside IDLE. A and B may change after acceptance.

Optional Feature:
- FP_ALIGN_FAST_SHIFT_EN defined: SHIFT moves min(4, remaining) bits per cycle, with all discarded bits ORed into S. K becomes ceil(D/4) for 0<D<SAT. Results are bit-identical to the undefined case.
- Undefined: one bit per cycle, as specified above.

Decomposition:
- Package fp_align_pkg holds:
  - state enum (IDLE, DIFF, NEG, SHIFT, DONE);
  - EXP_W, MAN_W and GRS_W=3;
  - SAT default;
  - function eff_exp(field) returning {exp, hidden}.
- Existing Sub8bits is instantiated once, with operand muxing done in this block.
- One new sub-module, fp_sticky_shr: a combinational right shift by N of 27 bits with sticky OR, shared by the single-bit and fast paths.

Test Plan:
- A=0x3F800000, B=0x3F800000: out_valid 1 clock after accept; Exp=0x7F, MantL=0x800000, MantS=0x4000000, Swap=0.
- A=0x3F800000, B=0x40800000: Swap=1, D=2, latency 4; Exp=0x81, MantL=0x800000, MantS=0x1000000, SignL=SignS=0.
- A=0x4B000000, B=0x3F800001: D=23, latency 24; MantS=0x0000009 (sticky set). With FP_ALIGN_FAST_SHIFT_EN, latency 7 and the same MantS.
- A=0x7F000000, B=0x3F800000: D=127 ≥ SAT, latency 2; MantS=0x0000001.
- Case 2 with out_ready=0 for 5 clocks: outputs stable and in_ready=0 throughout. in_ready returns the clock after the handshake; in_valid pulses during the hold are ignored.
- rst_n low during SHIFT of case 3: out_valid=0 immediately and all outputs 0. After release, case 1 completes with the expected values.

Source files
------------

// File: rtl/fp_align_pkg.sv
// fp_align_pkg: shared types, widths and helpers for the FP alignment sequencer.
//   - state_e   : sequencer states
//   - EXP_W / MAN_W / GRS_W / SIG_W / ALN_W / SAT_DEF : field and datapath widths
//   - STEP_MAX  : bits shifted per SHIFT cycle (4 with FP_ALIGN_FAST_SHIFT_EN, else 1)
//   - eff_exp() : effective exponent plus hidden bit of an exponent field
// Build option: FP_ALIGN_FAST_SHIFT_EN selects the multi-bit shift step.
package fp_align_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int GRS_W   = 3;
  localparam int SIG_W   = MAN_W + 1;
  localparam int ALN_W   = SIG_W + GRS_W;
  localparam int SAT_DEF = MAN_W + 4;

`ifdef FP_ALIGN_FAST_SHIFT_EN
  localparam int STEP_MAX = 4;
`else
  localparam int STEP_MAX = 1;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIFF  = 3'd1,
    NEG   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Returns {effective exponent, hidden bit}. A zero field is a denormal:
  // it behaves as exponent 1 with no hidden bit.
  function automatic logic [EXP_W:0] eff_exp(input logic [EXP_W-1:0] field);
    if (field == '0) begin
      return {{(EXP_W-1){1'b0}}, 1'b1, 1'b0};
    end
    return {field, 1'b1};
  endfunction

endpackage

// File: rtl/Sub8bits.sv
// Sub8bits: 8-bit subtractor F = A - B - Ci.
//   A, B : operands
//   Ci   : borrow in
//   F    : difference (mod 256)
//   Co   : borrow out (1 when A < B + Ci)
module Sub8bits (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Ci,
  output logic [7:0] F,
  output logic       Co
);

  logic [8:0] diff;

  assign diff = {1'b0, A} - {1'b0, B} - {8'd0, Ci};
  assign F    = diff[7:0];
  assign Co   = diff[8];

endmodule

// File: rtl/fp_sticky_shr.sv
// fp_sticky_shr: combinational logical right shift with sticky collection.
//   din_i  : value to shift, LSB is the sticky position
//   sh_i   : shift amount
//   dout_o : din_i >> sh_i, with every bit that passes through or below the
//            LSB ORed into the LSB
// Shifting by a then b gives the same result as shifting by a+b, so the
// single-bit and multi-bit step sizes produce identical results.
module fp_sticky_shr #(
  parameter int W    = 27,
  parameter int SH_W = 3
) (
  input  logic [W-1:0]    din_i,
  input  logic [SH_W-1:0] sh_i,
  output logic [W-1:0]    dout_o
);

  logic [W-1:0] shifted;
  logic [W-1:0] lost;

  assign shifted = din_i >> sh_i;
  // Bits strictly below the shift amount fall off the bottom.
  assign lost    = din_i & ~({W{1'b1}} << sh_i);
  assign dout_o  = {shifted[W-1:1], shifted[0] | (|lost)};

endmodule

// File: rtl/fp_align_seq.sv
// fp_align_seq: multicycle alignment sequencer for the FP add/sub path.
//   clk, rst_n           : clock, asynchronous active-low reset
//   A, B                 : single-precision operands, accepted on in_valid & in_ready
//   in_ready             : high in IDLE
//   out_valid, out_ready : result handshake, result held while out_valid
//   Exp                  : effective exponent of the larger operand
//   MantL                : larger significand with hidden bit
//   MantS                : smaller significand aligned, {24 bits, G, R, S}
//   SignL, SignS, Swap   : signs of L and S, Swap=1 when B supplied L
// Build option: FP_ALIGN_FAST_SHIFT_EN shifts up to 4 bits per SHIFT cycle.
module fp_align_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SAT   = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   Exp,
  output logic [MAN_W:0]     MantL,
  output logic [MAN_W+3:0]   MantS,
  output logic               SignL,
  output logic               SignS,
  output logic               Swap
);

  import fp_align_pkg::*;

  localparam logic [EXP_W-1:0] SAT_C  = EXP_W'(SAT);
  localparam logic [2:0]       STEP_C = 3'(STEP_MAX);

  state_e state_q, state_d;

  logic [31:0]      a_q, b_q;
  logic [EXP_W-1:0] cnt_q;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W:0]   mantl_q;
  logic [MAN_W+3:0] mants_q;
  logic             signl_q, signs_q, swap_q;

  logic [EXP_W:0]   ea, eb;
  logic [EXP_W-1:0] sub_x, sub_y, sub_f;
  logic             sub_co;
  logic [2:0]       step;
  logic             sat_hit, last_step;
  logic [MAN_W+3:0] shr_out;

  assign ea = eff_exp(a_q[MAN_W +: EXP_W]);
  assign eb = eff_exp(b_q[MAN_W +: EXP_W]);

  // One shared subtractor: A-B in DIFF, B-A in NEG.
  assign sub_x = (state_q == NEG) ? eb[EXP_W:1] : ea[EXP_W:1];
  assign sub_y = (state_q == NEG) ? ea[EXP_W:1] : eb[EXP_W:1];

  Sub8bits u_sub (
    .A  (sub_x),
    .B  (sub_y),
    .Ci (1'b0),
    .F  (sub_f),
    .Co (sub_co)
  );

  assign sat_hit   = (cnt_q >= SAT_C);
  assign step      = (cnt_q >= {{(EXP_W-3){1'b0}}, STEP_C}) ? STEP_C : cnt_q[2:0];
  assign last_step = (cnt_q == {{(EXP_W-3){1'b0}}, step});

  fp_sticky_shr #(
    .W    (MAN_W + 4),
    .SH_W (3)
  ) u_shr (
    .din_i  (mants_q),
    .sh_i   (step),
    .dout_o (shr_out)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (in_valid) state_d = DIFF;
      DIFF:  begin
        if (sub_co)             state_d = NEG;
        else if (sub_f != '0)   state_d = SHIFT;
        else                    state_d = DONE;
      end
      NEG:   state_d = (sub_f != '0) ? SHIFT : DONE;
      SHIFT: if (sat_hit || last_step) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      mantl_q <= '0;
      mants_q <= '0;
      signl_q <= 1'b0;
      signs_q <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q <= A;
            b_q <= B;
          end
        end
        DIFF: begin
          // Equal exponents keep A as L; no mantissa compare.
          if (!sub_co) begin
            exp_q   <= ea[EXP_W:1];
            mantl_q <= {ea[0], a_q[MAN_W-1:0]};
            mants_q <= {eb[0], b_q[MAN_W-1:0], 3'b000};
            signl_q <= a_q[31];
            signs_q <= b_q[31];
            swap_q  <= 1'b0;
            cnt_q   <= sub_f;
          end
        end
        NEG: begin
          exp_q   <= eb[EXP_W:1];
          mantl_q <= {eb[0], b_q[MAN_W-1:0]};
          mants_q <= {ea[0], a_q[MAN_W-1:0], 3'b000};
          signl_q <= b_q[31];
          signs_q <= a_q[31];
          swap_q  <= 1'b1;
          cnt_q   <= sub_f;
        end
        SHIFT: begin
          // Large differences push every bit past S in one cycle.
          if (sat_hit) begin
            mants_q <= {{(MAN_W+3){1'b0}}, |mants_q};
          end else begin
            mants_q <= shr_out;
            cnt_q   <= cnt_q - {{(EXP_W-3){1'b0}}, step};
          end
        end
        default: ;
      endcase
    end
  end

  assign Exp   = exp_q;
  assign MantL = mantl_q;
  assign MantS = mants_q;
  assign SignL = signl_q;
  assign SignS = signs_q;
  assign Swap  = swap_q;

endmodule

// File: tb/tb_fp_align_seq.sv
// tb_fp_align_seq: directed and randomized checks of fp_align_seq against a
// reference model computed from effective exponents and wide integer shifts.
module tb_fp_align_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  Exp;
  logic [23:0] MantL;
  logic [26:0] MantS;
  logic        SignL, SignS, Swap;

  int checks = 0;
  int errors = 0;

  fp_align_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Exp       (Exp),
    .MantL     (MantL),
    .MantS     (MantS),
    .SignL     (SignL),
    .SignS     (SignS),
    .Swap      (Swap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  exp;
    logic [23:0] mantl;
    logic [26:0] mants;
    logic        signl;
    logic        signs;
    logic        swap;
    int          lat;
  } res_t;

  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    int     ea, eb, d, k;
    longint sa, sb, x, lost;
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    sa = longint'(a[22:0]) + ((a[30:23] != 8'd0) ? 64'h800000 : 64'd0);
    sb = longint'(b[22:0]) + ((b[30:23] != 8'd0) ? 64'h800000 : 64'd0);
    r.swap = (ea < eb);
    if (r.swap) begin
      r.exp = 8'(eb); r.mantl = 24'(sb); x = sa * 8; d = eb - ea;
      r.signl = b[31]; r.signs = a[31];
    end else begin
      r.exp = 8'(ea); r.mantl = 24'(sa); x = sb * 8; d = ea - eb;
      r.signl = a[31]; r.signs = b[31];
    end
    if (d == 0) begin
      r.mants = 27'(x); k = 0;
    end else if (d >= 27) begin
      r.mants = (x != 0) ? 27'd1 : 27'd0; k = 1;
    end else begin
      lost = x % (longint'(1) << (d + 1));
      r.mants = 27'((x >> d) | ((lost != 0) ? 64'd1 : 64'd0));
`ifdef FP_ALIGN_FAST_SHIFT_EN
      k = (d + 3) / 4;
`else
      k = d;
`endif
    end
    r.lat = 1 + int'(r.swap) + k;
    return r;
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int hold, input string name);
    res_t r;
    int   lat;
    r = ref_model(a, b);
    @(negedge clk);
    check({name, ".in_ready_idle"}, in_ready, 1);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; A = $urandom; B = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 400);
    check({name, ".latency"}, lat, r.lat);
    check({name, ".out_valid"}, out_valid, 1);
    check({name, ".in_ready_busy"}, in_ready, 0);
    check({name, ".Exp"}, Exp, r.exp);
    check({name, ".MantL"}, MantL, r.mantl);
    check({name, ".MantS"}, MantS, r.mants);
    check({name, ".SignL"}, SignL, r.signl);
    check({name, ".SignS"}, SignS, r.signs);
    check({name, ".Swap"}, Swap, r.swap);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); A = $urandom; B = $urandom;
      @(posedge clk);
      @(negedge clk);
      check({name, ".hold_valid"}, out_valid, 1);
      check({name, ".hold_ready"}, in_ready, 0);
      check({name, ".hold_MantS"}, MantS, r.mants);
      check({name, ".hold_Exp"}, Exp, r.exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ".released_valid"}, out_valid, 0);
    check({name, ".released_ready"}, in_ready, 1);
    $display("txn %s A=%08h B=%08h lat=%0d Exp=%02h MantS=%07h Swap=%0d",
             name, a, b, lat, Exp, MantS, Swap);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    @(negedge clk);
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.MantS", MantS, 0);
    check("rst.Exp", Exp, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(32'h3F800000, 32'h3F800000, 0, "equal");
    run_txn(32'h3F800000, 32'h40800000, 0, "swap_d2");
    run_txn(32'h4B000000, 32'h3F800001, 0, "d23_sticky");
    run_txn(32'h7F000000, 32'h3F800000, 0, "saturate");
    run_txn(32'h3F800000, 32'h40800000, 5, "swap_hold5");
    run_txn(32'h00000005, 32'h80800003, 0, "denorm_norm");

    // Reset in the middle of a long shift
    @(negedge clk);
    A = 32'h4B000000; B = 32'h3F800001; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst.pre_MantL", MantL, 24'h800000);
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.in_ready", in_ready, 1);
    check("midrst.Exp", Exp, 0);
    check("midrst.MantL", MantL, 0);
    check("midrst.MantS", MantS, 0);
    check("midrst.flags", {SignL, SignS, Swap}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(32'h3F800000, 32'h3F800000, 0, "post_reset");

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: begin
          e  = ra[30:23] + 8'($urandom_range(0, 30)) - 8'd15;
          rb = {1'($urandom), e, 23'($urandom)};
        end
        2: begin
          ra[30:23] = 8'd0;
          rb = {1'($urandom), 8'($urandom_range(0, 6)), 23'($urandom)};
        end
        default: begin
          rb = {1'($urandom), ra[30:23], 23'($urandom)};
        end
      endcase
      run_txn(ra, rb, $urandom_range(0, 2), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
